// File: rtl/image_frame_capture_if.sv
// image_frame_capture_if: sensor, FIFO and status signals of the frame capture block
//   fv, lv, pix      sensor frame valid, line valid, pixel data (PIX_W)
//   capture_req      one-cycle pulse that arms capture of the next full frame
//   fifo_full        downstream FIFO full
//   out_valid/data   FIFO write enable and zero-extended 16-bit pixel word
//   out_sof/out_eol  first word of frame / last word of line
//   capture_busy     armed or capturing
//   capture_done     one-cycle pulse at frame end
//   frame_cols/rows  geometry of the last captured frame
//   frame_error      [0] word dropped on full FIFO, [1] ragged line length (sticky)
// master drives the sensor/control side; slave is the capture block.
interface image_frame_capture_if #(
    parameter int PIX_W = 12,
    parameter int COL_W = 12,
    parameter int ROW_W = 12
);
    logic             fv;
    logic             lv;
    logic [PIX_W-1:0] pix;
    logic             capture_req;
    logic             fifo_full;
    logic             out_valid;
    logic [15:0]      out_data;
    logic             out_sof;
    logic             out_eol;
    logic             capture_busy;
    logic             capture_done;
    logic [COL_W-1:0] frame_cols;
    logic [ROW_W-1:0] frame_rows;
    logic [1:0]       frame_error;

    modport master (
        output fv, lv, pix, capture_req, fifo_full,
        input  out_valid, out_data, out_sof, out_eol, capture_busy, capture_done,
               frame_cols, frame_rows, frame_error
    );

    modport slave (
        input  fv, lv, pix, capture_req, fifo_full,
        output out_valid, out_data, out_sof, out_eol, capture_busy, capture_done,
               frame_cols, frame_rows, frame_error
    );
endinterface

// File: rtl/image_frame_capture.sv
// image_frame_capture: captures one sensor frame per request into a 16-bit write FIFO
//   i_pixclk   pixel clock, the only clock
//   i_reset    synchronous active-high reset
//   io_bus     slave side of image_frame_capture_if (sensor in, FIFO writes and status out)
// A pixel sampled at edge k is written after edge k+2: stage 1 registers the sensor,
// stage 2 holds one pixel back so its end-of-line flag is known when it is emitted.
module image_frame_capture #(
    parameter int PIX_W = 12,
    parameter int COL_W = 12,
    parameter int ROW_W = 12
) (
    input logic                  i_pixclk,
    input logic                  i_reset,
    image_frame_capture_if.slave io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t           r_state, w_next;
    logic             r_fv, r_lv, r_fv_d;
    logic [PIX_W-1:0] r_pix, r_pend_pix;
    logic             r_pend_v, r_first;
    logic             r_out_valid, r_out_sof, r_out_eol, r_done;
    logic [15:0]      r_out_data;
    logic [COL_W-1:0] r_col, r_ref, r_cols, w_len;
    logic [ROW_W-1:0] r_row, r_rows, w_row_inc;
    logic [1:0]       r_err;
    logic             w_elv, w_rise, w_fall, w_accept, w_start, w_done, w_write;

    assign w_elv     = r_lv & r_fv;
    assign w_rise    = r_fv & ~r_fv_d;
    assign w_fall    = ~r_fv & r_fv_d;
    assign w_write   = r_pend_v & ~io_bus.fifo_full;
    // Line length including the word being emitted now; both counters stick at all-ones.
    assign w_len     = &r_col ? r_col : r_col + COL_W'(1);
    assign w_row_inc = &r_row ? r_row : r_row + ROW_W'(1);

    always_comb begin
        w_accept = r_state == S_IDLE && io_bus.capture_req;
        w_start  = r_state == S_ARMED && w_rise;
        w_done   = r_state == S_DONE;
        w_next   = w_accept ? S_ARMED :
                   w_start ? S_CAPTURE :
                   (r_state == S_CAPTURE && w_fall) ? S_DONE :
                   w_done ? S_IDLE : r_state;
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            r_fv        <= 1'b0;
            r_lv        <= 1'b0;
            r_fv_d      <= 1'b0;
            r_pix       <= '0;
            r_pend_pix  <= '0;
            r_pend_v    <= 1'b0;
            r_first     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
            r_col       <= '0;
            r_ref       <= '0;
            r_row       <= '0;
            r_cols      <= '0;
            r_rows      <= '0;
            r_err       <= '0;
        end else begin
            r_fv     <= io_bus.fv;
            r_lv     <= io_bus.lv;
            r_pix    <= io_bus.pix;
            r_fv_d   <= r_fv;
            // The arming edge itself may already carry the first pixel of the frame.
            r_pend_v <= w_elv && (r_state == S_CAPTURE || w_start);
            if (w_elv) r_pend_pix <= r_pix;
            // A pending pixel with no valid successor closes its line (also on fv falling).
            r_out_valid <= w_write;
            r_out_sof   <= w_write && r_first;
            r_out_eol   <= w_write && !w_elv;
            if (r_pend_v) r_out_data <= 16'(r_pend_pix);
            if (w_start) r_first <= 1'b1;
            else if (r_pend_v) r_first <= 1'b0;
            if (w_accept) begin
                r_col <= '0;
                r_row <= '0;
                r_ref <= '0;
                r_err <= '0;
            end else if (r_pend_v) begin
                r_err[0] <= r_err[0] | io_bus.fifo_full;
                if (w_elv) r_col <= w_len;
                else begin
                    r_col <= '0;
                    r_row <= w_row_inc;
                    if (r_row == '0) r_ref <= w_len;
                    else if (w_len != r_ref) r_err[1] <= 1'b1;
                end
            end
            r_done <= w_done;
            if (w_done) begin
                r_cols <= r_ref;
                r_rows <= r_row;
            end
        end
    end

    assign io_bus.out_valid    = r_out_valid;
    assign io_bus.out_data     = r_out_data;
    assign io_bus.out_sof      = r_out_sof;
    assign io_bus.out_eol      = r_out_eol;
    assign io_bus.capture_busy = r_state == S_ARMED || r_state == S_CAPTURE;
    assign io_bus.capture_done = r_done;
    assign io_bus.frame_cols   = r_cols;
    assign io_bus.frame_rows   = r_rows;
    assign io_bus.frame_error  = r_err;
endmodule
